mc_ctrl_fsm: RTL and testbench

- Multi-cycle MIPS control sequencer. Steps one instruction through FETCH/DECODE/EXE/MEM/WB states.
- Owns the instruction register (IR). Drives every write strobe and mux select of the shared multi-cycle datapath: PC, IR, GRF, DM, ALU, EXT, NPC.
- Instruction set: add, addu, sub, subu, and, or, xor, sll, srl, jr, nop, addi, addiu, ori, lui, lw, sw, beq, bne, j, jal.

---
 rtl/mc_ctrl_fsm.sv | 192 +++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: owns IR and walks FETCH/DECODE/EXE/MEM/WB.
// Optional MC_CTRL_MEM_WAIT_EN adds a MemReady handshake that stalls FETCH and MEM.
module mc_ctrl_fsm #(
  parameter logic [31:0] RESET_IR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
`ifdef MC_CTRL_MEM_WAIT_EN
  input  logic        MemReady,
`endif
  output logic [31:0] IR,
  output logic [2:0]  State,
  output logic        PCWr,
  output logic        IRWr,
  output logic [1:0]  NPCOp,
  output logic [1:0]  RegDst,
  output logic        ALUSrc,
  output logic [1:0]  MemtoReg,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic [1:0]  ExtOp,
  output logic [3:0]  ALUCtr
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t      state_r, next_s;
  logic [31:0] ir_r;
  logic        mem_ready_s;

`ifdef MC_CTRL_MEM_WAIT_EN
  assign mem_ready_s = MemReady;
`else
  assign mem_ready_s = 1'b1;
`endif

  logic [5:0] op_s, funct_s;
  logic [3:0] r_aluctr_s;
  logic       r_known_s, is_nop_s, is_r_s, is_jr_s, is_imm_s;
  logic       is_ori_s, is_lui_s, is_lw_s, is_sw_s, is_beq_s, is_bne_s, is_j_s, is_jal_s;

  // Instruction classification from the latched IR.
  always_comb begin
    op_s       = ir_r[31:26];
    funct_s    = ir_r[5:0];
    r_known_s  = 1'b1;
    r_aluctr_s = 4'b0000;
    case (funct_s)
      6'h20, 6'h21: r_aluctr_s = 4'b0000;
      6'h22, 6'h23: r_aluctr_s = 4'b0001;
      6'h24:        r_aluctr_s = 4'b0010;
      6'h25:        r_aluctr_s = 4'b0011;
      6'h26:        r_aluctr_s = 4'b0100;
      6'h00:        r_aluctr_s = 4'b0101;
      6'h02:        r_aluctr_s = 4'b0110;
      default:      r_known_s  = 1'b0;
    endcase
    is_nop_s = (ir_r == 32'h0000_0000);
    // sll with all-zero fields is nop; jr is its own class (funct 08 is not r_known)
    is_r_s   = (op_s == 6'h00) && !is_nop_s && r_known_s;
    is_jr_s  = (op_s == 6'h00) && (funct_s == 6'h08);
    is_ori_s = (op_s == 6'h0D);
    is_lui_s = (op_s == 6'h0F);
    is_imm_s = (op_s == 6'h08) || (op_s == 6'h09) || is_ori_s || is_lui_s;
    is_lw_s  = (op_s == 6'h23);
    is_sw_s  = (op_s == 6'h2B);
    is_beq_s = (op_s == 6'h04);
    is_bne_s = (op_s == 6'h05);
    is_j_s   = (op_s == 6'h02);
    is_jal_s = (op_s == 6'h03);
  end

  logic       pc_wr_s, ir_wr_s, reg_write_s, mem_write_s, alu_src_s;
  logic [1:0] npc_op_s, reg_dst_s, mem_to_reg_s, ext_op_s;
  logic [3:0] alu_ctr_s;

  // Output decode and next-state logic; everything held at zero while reset is high.
  always_comb begin
    pc_wr_s      = 1'b0;
    ir_wr_s      = 1'b0;
    reg_write_s  = 1'b0;
    mem_write_s  = 1'b0;
    alu_src_s    = 1'b0;
    npc_op_s     = 2'b00;
    reg_dst_s    = 2'b00;
    mem_to_reg_s = 2'b00;
    ext_op_s     = 2'b00;
    alu_ctr_s    = 4'b0000;
    next_s       = S_FETCH;
    if (reset) begin
      next_s = S_FETCH;
    end else begin
      reg_dst_s    = is_r_s ? 2'b01 : (is_jal_s ? 2'b10 : 2'b00);
      mem_to_reg_s = is_lw_s ? 2'b01 : (is_jal_s ? 2'b10 : 2'b00);
      alu_src_s    = is_imm_s || is_lw_s || is_sw_s;
      ext_op_s     = is_ori_s ? 2'b10 : (is_lui_s ? 2'b01 : 2'b00);
      alu_ctr_s    = is_r_s ? r_aluctr_s :
                     (is_beq_s || is_bne_s) ? 4'b0001 :
                     is_ori_s ? 4'b0011 : 4'b0000;
      npc_op_s     = (is_j_s || is_jal_s) ? 2'b10 :
                     is_jr_s ? 2'b11 :
                     (is_beq_s || is_bne_s) ? 2'b01 : 2'b00;
      case (state_r)
        S_FETCH: begin
          npc_op_s = 2'b00;
          ir_wr_s  = mem_ready_s;
          pc_wr_s  = mem_ready_s;
          next_s   = mem_ready_s ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          if (is_j_s || is_jal_s || is_jr_s) begin
            pc_wr_s     = 1'b1;
            reg_write_s = is_jal_s;
            next_s      = S_FETCH;
          end else if (is_r_s || is_imm_s || is_lw_s || is_sw_s || is_beq_s || is_bne_s) begin
            next_s = S_EXE;
          end else begin
            next_s = S_FETCH;
          end
        end
        S_EXE: begin
          if (is_beq_s) begin
            pc_wr_s = Zero;
            next_s  = S_FETCH;
          end else if (is_bne_s) begin
            pc_wr_s = ~Zero;
            next_s  = S_FETCH;
          end else if (is_lw_s || is_sw_s) begin
            next_s = S_MEM;
          end else if (is_r_s || is_imm_s) begin
            next_s = S_WB;
          end else begin
            next_s = S_FETCH;
          end
        end
        S_MEM: begin
          // sw keeps MemWrite up across the whole hold; the memory commits on MemReady
          if (is_sw_s) begin
            mem_write_s = 1'b1;
            next_s      = mem_ready_s ? S_FETCH : S_MEM;
          end else if (is_lw_s) begin
            next_s = mem_ready_s ? S_WB : S_MEM;
          end else begin
            next_s = S_FETCH;
          end
        end
        S_WB: begin
          reg_write_s = is_r_s || is_imm_s || is_lw_s;
          next_s      = S_FETCH;
        end
        default: begin
          next_s = S_FETCH;
        end
      endcase
    end
  end

  // State register and instruction register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_FETCH;
      ir_r    <= RESET_IR;
    end else begin
      state_r <= next_s;
      if (ir_wr_s) begin
        ir_r <= Instr;
      end
    end
  end

  assign IR       = ir_r;
  assign State    = state_r;
  assign PCWr     = pc_wr_s;
  assign IRWr     = ir_wr_s;
  assign NPCOp    = npc_op_s;
  assign RegDst   = reg_dst_s;
  assign ALUSrc   = alu_src_s;
  assign MemtoReg = mem_to_reg_s;
  assign RegWrite = reg_write_s;
  assign MemWrite = mem_write_s;
  assign ExtOp    = ext_op_s;
  assign ALUCtr   = alu_ctr_s;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-instruction state walks, strobes and selects.
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Instr = 32'h0000_0000;
  logic        Zero = 1'b0;
  logic [31:0] IR;
  logic [2:0]  State;
  logic        PCWr, IRWr, ALUSrc, RegWrite, MemWrite;
  logic [1:0]  NPCOp, RegDst, MemtoReg, ExtOp;
  logic [3:0]  ALUCtr;
`ifdef MC_CTRL_MEM_WAIT_EN
  logic        mem_ready = 1'b1;
`endif

  int n_vec = 0;
  int n_err = 0;

  mc_ctrl_fsm dut (
    .clk(clk), .reset(reset), .Instr(Instr), .Zero(Zero),
`ifdef MC_CTRL_MEM_WAIT_EN
    .MemReady(mem_ready),
`endif
    .IR(IR), .State(State), .PCWr(PCWr), .IRWr(IRWr), .NPCOp(NPCOp),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .ExtOp(ExtOp), .ALUCtr(ALUCtr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] strobes;   // {State, PCWr, IRWr, RegWrite, MemWrite}
    logic [1:0] npc, regdst, memtoreg, extop;
    logic       alusrc;
    logic [3:0] aluctr;
  } snap_t;

  snap_t      obs [0:7];
  logic [2:0] end_state;

  localparam logic [6:0] C_F  = 7'b000_1100;
  localparam logic [6:0] C_D  = 7'b001_0000;
  localparam logic [6:0] C_E  = 7'b010_0000;
  localparam logic [6:0] C_M  = 7'b011_0000;
  localparam logic [6:0] C_MW = 7'b011_0001;
  localparam logic [6:0] C_W  = 7'b100_0010;
  localparam logic [6:0] C_DJ = 7'b001_1000;
  localparam logic [6:0] C_DL = 7'b001_1010;
  localparam logic [6:0] C_ET = 7'b010_1000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one instruction from FETCH for n cycles, recording outputs every cycle.
  task automatic exec(input logic [31:0] instr, input logic zero, input int n);
    Instr = instr;
    Zero  = zero;
    #1;
    for (int i = 0; i < n; i++) begin
      obs[i].strobes  = {State, PCWr, IRWr, RegWrite, MemWrite};
      obs[i].npc      = NPCOp;
      obs[i].regdst   = RegDst;
      obs[i].memtoreg = MemtoReg;
      obs[i].extop    = ExtOp;
      obs[i].alusrc   = ALUSrc;
      obs[i].aluctr   = ALUCtr;
      tick();
    end
    end_state = State;
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if ({State, IR, PCWr, IRWr, RegWrite, MemWrite, NPCOp, RegDst, MemtoReg, ExtOp, ALUSrc, ALUCtr} !== 56'h0) begin
      n_err++;
      $display("FAIL reset_hold: state=%0d ir=%h strobes=%b%b%b%b", State, IR, PCWr, IRWr, RegWrite, MemWrite);
    end
    Instr = 32'h0022_1821;
    reset = 1'b0;
    #1;
    n_vec++;
    if ({State, IRWr, PCWr} !== 5'b000_11) begin
      n_err++;
      $display("FAIL first_fetch: got %b want 00011", {State, IRWr, PCWr});
    end
    tick();
    tick();
    n_vec++;
    if (State !== 3'd2 || IR !== 32'h0022_1821) begin
      n_err++;
      $display("FAIL pre_reset_exe: state=%0d ir=%h want 2 00221821", State, IR);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if (State !== 3'd0 || IR !== 32'h0 || RegWrite !== 1'b0 || IRWr !== 1'b0 || PCWr !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: state=%0d ir=%h regwr=%b irwr=%b want 0 0 0 0", State, IR, RegWrite, IRWr);
    end
    #1 reset = 1'b0;
    Instr = 32'h8C05_0004;
    tick();
    n_vec++;
    if (State !== 3'd1 || IR !== 32'h8C05_0004) begin
      n_err++;
      $display("FAIL post_reset_latch: state=%0d ir=%h want 1 8c050004", State, IR);
    end
    repeat (4) tick();
    n_vec++;
    if (State !== 3'd0) begin
      n_err++;
      $display("FAIL post_reset_lw_done: state=%0d want 0", State);
    end
  endtask

  // R-type and immediate ALU: 4 cycles, WB selects per instruction.
  task automatic test_alu();
    logic [31:0] ins [0:8] = '{32'h0022_1821, 32'h0022_1822, 32'h0022_1824, 32'h0022_1826,
                               32'h0002_1882, 32'h0002_1880, 32'h3423_0005, 32'h3C03_1234, 32'h2023_0005};
    // {regdst, memtoreg, alusrc, extop, aluctr}
    logic [10:0] wb [0:8] = '{{2'b01, 2'b00, 1'b0, 2'b00, 4'b0000}, {2'b01, 2'b00, 1'b0, 2'b00, 4'b0001},
                              {2'b01, 2'b00, 1'b0, 2'b00, 4'b0010}, {2'b01, 2'b00, 1'b0, 2'b00, 4'b0100},
                              {2'b01, 2'b00, 1'b0, 2'b00, 4'b0110}, {2'b01, 2'b00, 1'b0, 2'b00, 4'b0101},
                              {2'b00, 2'b00, 1'b1, 2'b10, 4'b0011}, {2'b00, 2'b00, 1'b1, 2'b01, 4'b0000},
                              {2'b00, 2'b00, 1'b1, 2'b00, 4'b0000}};
    logic [6:0] seq [0:3] = '{C_F, C_D, C_E, C_W};
    for (int k = 0; k < 9; k++) begin
      exec(ins[k], 1'b0, 4);
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (obs[i].strobes !== seq[i]) begin
          n_err++;
          $display("FAIL alu_%h_cyc%0d: got %b want %b", ins[k], i, obs[i].strobes, seq[i]);
        end
      end
      n_vec++;
      if ({obs[3].regdst, obs[3].memtoreg, obs[3].alusrc, obs[3].extop, obs[3].aluctr} !== wb[k] || end_state !== 3'd0) begin
        n_err++;
        $display("FAIL alu_%h_wb: got %b end=%0d want %b end=0", ins[k],
                 {obs[3].regdst, obs[3].memtoreg, obs[3].alusrc, obs[3].extop, obs[3].aluctr}, end_state, wb[k]);
      end
    end
  endtask

  task automatic test_mem();
    logic [6:0] lw_seq [0:4] = '{C_F, C_D, C_E, C_M, C_W};
    logic [6:0] sw_seq [0:3] = '{C_F, C_D, C_E, C_MW};
    exec(32'h8C05_0004, 1'b0, 5);
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (obs[i].strobes !== lw_seq[i]) begin
        n_err++;
        $display("FAIL lw_cyc%0d: got %b want %b", i, obs[i].strobes, lw_seq[i]);
      end
    end
    n_vec++;
    if ({obs[4].memtoreg, obs[4].regdst, obs[2].alusrc, obs[2].extop, obs[2].aluctr, end_state} !== 14'b01_00_1_00_0000_000) begin
      n_err++;
      $display("FAIL lw_sel: memtoreg=%b regdst=%b alusrc=%b end=%0d want 01 00 1 0",
               obs[4].memtoreg, obs[4].regdst, obs[2].alusrc, end_state);
    end
    exec(32'hAC05_0004, 1'b0, 4);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (obs[i].strobes !== sw_seq[i]) begin
        n_err++;
        $display("FAIL sw_cyc%0d: got %b want %b", i, obs[i].strobes, sw_seq[i]);
      end
    end
    n_vec++;
    if (end_state !== 3'd0 || obs[2].alusrc !== 1'b1) begin
      n_err++;
      $display("FAIL sw_end: end=%0d alusrc=%b want 0 1", end_state, obs[2].alusrc);
    end
  endtask

  task automatic test_branch();
    logic [31:0] ins [0:3] = '{32'h1022_0003, 32'h1022_0003, 32'h1422_0003, 32'h1422_0003};
    logic        z   [0:3] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [6:0]  ex  [0:3] = '{C_ET, C_E, C_ET, C_E};
    for (int k = 0; k < 4; k++) begin
      exec(ins[k], z[k], 3);
      n_vec++;
      if (obs[0].strobes !== C_F || obs[1].strobes !== C_D || obs[2].strobes !== ex[k] ||
          obs[2].npc !== 2'b01 || obs[2].aluctr !== 4'b0001 || end_state !== 3'd0) begin
        n_err++;
        $display("FAIL branch%0d: exe=%b npc=%b alu=%b end=%0d want %b 01 0001 0",
                 k, obs[2].strobes, obs[2].npc, obs[2].aluctr, end_state, ex[k]);
      end
    end
  endtask

  task automatic test_jump();
    logic [31:0] ins [0:4] = '{32'h0C00_0010, 32'h0800_0010, 32'h03E0_0008, 32'h0000_0000, 32'hFC00_0000};
    logic [6:0]  dec [0:4] = '{C_DL, C_DJ, C_DJ, C_D, C_D};
    logic [1:0]  npc [0:4] = '{2'b10, 2'b10, 2'b11, 2'b00, 2'b00};
    for (int k = 0; k < 5; k++) begin
      exec(ins[k], 1'b0, 2);
      n_vec++;
      if (obs[0].strobes !== C_F || obs[0].npc !== 2'b00 || obs[1].strobes !== dec[k] ||
          obs[1].npc !== npc[k] || end_state !== 3'd0) begin
        n_err++;
        $display("FAIL jump_%h: dec=%b npc=%b end=%0d want %b %b 0",
                 ins[k], obs[1].strobes, obs[1].npc, end_state, dec[k], npc[k]);
      end
    end
    exec(32'h0C00_0010, 1'b0, 2);
    n_vec++;
    if (obs[1].regdst !== 2'b10 || obs[1].memtoreg !== 2'b10) begin
      n_err++;
      $display("FAIL jal_sel: regdst=%b memtoreg=%b want 10 10", obs[1].regdst, obs[1].memtoreg);
    end
  endtask

  task automatic test_back_to_back();
    exec(32'h0000_0000, 1'b0, 2);
    exec(32'h0022_1821, 1'b0, 4);
    exec(32'h0800_0010, 1'b0, 2);
    n_vec++;
    if (State !== 3'd0 || IR !== 32'h0800_0010) begin
      n_err++;
      $display("FAIL back_to_back: state=%0d ir=%h want 0 08000010", State, IR);
    end
  endtask

`ifdef MC_CTRL_MEM_WAIT_EN
  task automatic test_mem_wait();
    Instr = 32'hAC05_0004;
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({State, IRWr, PCWr} !== 5'b000_00) begin
        n_err++;
        $display("FAIL fetch_hold%0d: got %b want 00000", i, {State, IRWr, PCWr});
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    n_vec++;
    if ({State, IRWr, PCWr} !== 5'b000_11) begin
      n_err++;
      $display("FAIL fetch_release: got %b want 00011", {State, IRWr, PCWr});
    end
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    n_vec++;
    if (State !== 3'd3 || MemWrite !== 1'b1) begin
      n_err++;
      $display("FAIL mem_hold: state=%0d memwr=%b want 3 1", State, MemWrite);
    end
    mem_ready = 1'b1;
    tick();
    n_vec++;
    if (State !== 3'd0) begin
      n_err++;
      $display("FAIL mem_release: state=%0d want 0", State);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_jump();
    test_back_to_back();
`ifdef MC_CTRL_MEM_WAIT_EN
    test_mem_wait();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
